rotating_row_mux: RTL
=====================

ROTATING_ROW_MUX -- requirements
Module: rotating_row_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the bit width of one channel.
REQ-002 SHALL have parameter NUM_CH, default 6, the channel count; legal range 2..16.
REQ-003 SHALL have parameter SEL_WIDTH, default 3, the width of select and base_ptr; it SHALL satisfy 2**SEL_WIDTH >= NUM_CH.
REQ-004 SHALL have parameter OFFSET, default 1, a fixed channel offset in the range 0..NUM_CH-1.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port data_in, input, NUM_CH*DATA_WIDTH bits: channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port select, input, SEL_WIDTH bits: the logical channel request.
REQ-009 SHALL have port valid_in, input, 1 bit: qualifies select and data_in in the current cycle.
REQ-010 SHALL have port advance, input, 1 bit: a one-cycle line-end strobe that rotates the base pointer.
REQ-011 SHALL have port clear, input, 1 bit: a synchronous base-pointer clear.
REQ-012 SHALL have port data_out, output, DATA_WIDTH bits: the registered selected channel.
REQ-013 SHALL have port valid_out, output, 1 bit: data_out was updated this cycle.
REQ-014 SHALL have port sel_err, output, 1 bit: the registered illegal-select flag.
REQ-015 SHALL have port base_ptr, output, SEL_WIDTH bits: the current rotation base.

Function
REQ-016 The physical index SHALL be computed as idx = (base_ptr + select + OFFSET) mod NUM_CH, using base_ptr as it stands before any update in the same cycle.
REQ-017 The modulo SHALL be computed without truncation: the sum is carried at SEL_WIDTH+2 bits, with at most two conditional subtractions of NUM_CH.
REQ-018 Latency SHALL be 1 cycle: when valid_in=1 and select<NUM_CH at edge n, data_out = data_in[idx] and valid_out=1 after edge n.
REQ-019 When valid_in=1 and select>=NUM_CH, data_out SHALL hold its previous value, sel_err=1 and valid_out=0 for one cycle.
REQ-020 When valid_in=0, data_out SHALL hold its value and valid_out=0 and sel_err=0.
REQ-021 When advance=1 and clear=0, base_ptr SHALL increment by 1 at the edge, wrapping from NUM_CH-1 to 0.
REQ-022 When clear=1, base_ptr SHALL become 0 at the edge; clear has priority over a simultaneous advance.
REQ-023 An advance or clear in the same cycle as valid_in=1 SHALL NOT affect that transfer's idx (per REQ-016); the new base applies from the next cycle.
REQ-024 advance held high for k cycles SHALL rotate base_ptr k times (mod NUM_CH); there is no edge detection.
REQ-025 The block SHALL have no combinational path from any input to any output.
REQ-026 Behaviour for parameter values outside legal ranges is undefined; the RTL SHALL carry a comment check only (no runtime logic).

Reset
REQ-027 While reset=1, asynchronously: data_out=0, valid_out=0, sel_err=0, base_ptr=0.
REQ-028 On deassertion of reset, the first edge SHALL process its inputs normally; reset asserted mid-transfer SHALL discard that transfer.

Verification (NUM_CH=6, OFFSET=1, DATA_WIDTH=8, channel c driven with value 8'h10+c)
REQ-029 Case: base=0; select=0..5 with valid_in=1 on successive cycles -> data_out = 11,12,13,14,15,10 (hex), each one cycle later, with valid_out=1.
REQ-030 Case: pulse advance 5 times, then once more -> base_ptr = 1,2,3,4,5,0; with base=5 and select=0 -> data_out=8'h10.
REQ-031 Case: advance and valid_in in the same cycle with base=2 and select=1 -> data_out=8'h14; a repeat of the same request in the next cycle -> 8'h15.
REQ-032 Case: advance=1 and clear=1 together with base=3 -> base_ptr=0; clear alone with base=4 -> base_ptr=0.
REQ-033 Case: select=6 and select=7 with valid_in=1 -> sel_err=1, valid_out=0, data_out unchanged from the prior value.
REQ-034 Case: reset asserted mid-stream between edges -> all outputs 0 immediately; after release, select=0 -> 8'h11.

Source files
------------

// File: rtl/rotating_row_mux.sv
// Rotating channel selector: picks one of NUM_CH lanes at (base + select + OFFSET) mod NUM_CH,
// registering the result one cycle later. The base rotates on each line-end advance strobe.
module rotating_row_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 6,   // legal 2..16
    parameter int SEL_WIDTH  = 3,   // must satisfy 2**SEL_WIDTH >= NUM_CH
    parameter int OFFSET     = 1    // legal 0..NUM_CH-1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [SEL_WIDTH-1:0]         select,
    input  logic                         valid_in,
    input  logic                         advance,
    input  logic                         clear,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic                         sel_err,
    output logic [SEL_WIDTH-1:0]         base_ptr
);

    // Out-of-range parameters are not checked in hardware; the legal ranges above are the contract.
    localparam int SW = SEL_WIDTH + 2;
    localparam logic [SW-1:0]        NCH_W  = SW'(NUM_CH);
    localparam logic [SW-1:0]        OFF_W  = SW'(OFFSET);
    localparam logic [SEL_WIDTH-1:0] LAST_B = SEL_WIDTH'(NUM_CH - 1);

    logic [DATA_WIDTH-1:0] ch [NUM_CH];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_unpack
            assign ch[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [SEL_WIDTH-1:0]  base_q, base_d;

    logic [SW-1:0]         sum, sum1, idx;
    logic                  legal;
    logic [DATA_WIDTH-1:0] sel_data;

    // Each addend is below NUM_CH when the select is legal, so two subtractions reduce fully.
    always_comb begin
        sum  = {2'b00, base_q} + {2'b00, select} + OFF_W;
        sum1 = (sum  >= NCH_W) ? sum  - NCH_W : sum;
        idx  = (sum1 >= NCH_W) ? sum1 - NCH_W : sum1;
        legal = ({2'b00, select} < NCH_W);
    end

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx == SW'(c)) sel_data = ch[c];
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        base_d  = base_q;
        if (valid_in) begin
            if (legal) begin
                data_d  = sel_data;
                valid_d = 1'b1;
            end else begin
                err_d   = 1'b1;
            end
        end
        if (clear) begin
            base_d = '0;
        end else if (advance) begin
            base_d = (base_q == LAST_B) ? '0 : base_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            base_q  <= base_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sel_err   = err_q;
    assign base_ptr  = base_q;

endmodule
